// File: rtl/ysyx_24090018_ifu_fetch.sv
// ysyx_24090018_ifu_fetch: blocking instruction fetch with one outstanding request,
// redirect handling and draining of abandoned responses.
module ysyx_24090018_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_err_o
);
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d, ipc_q, ipc_d;
    logic            err_q, err_d;
    logic            hs;

    assign imem_req_valid_o = state_q == S_REQ;
    assign inst_valid_o     = state_q == S_OUT;
    assign imem_req_addr_o  = pc_q;
    assign inst_o           = inst_q;
    assign inst_pc_o        = ipc_q;
    assign inst_err_o       = err_q;
    assign hs               = imem_req_valid_o && imem_req_ready_i;

    // A redirect overrides everything; an accepted-but-unanswered request forces DRAIN.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        err_d   = err_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ~XLEN'(3);
            case (state_q)
                S_REQ:   state_d = hs ? S_DRAIN : S_REQ;
                S_OUT:   state_d = S_REQ;
                default: state_d = imem_rsp_valid_i ? S_REQ : S_DRAIN;
            endcase
        end else begin
            case (state_q)
                S_REQ:   state_d = hs ? S_WAIT : S_REQ;
                S_WAIT:
                    if (imem_rsp_valid_i) begin
                        state_d = S_OUT;
                        inst_d  = imem_rsp_err_i ? NOP : imem_rsp_data_i;
                        ipc_d   = pc_q;
                        err_d   = imem_rsp_err_i;
                    end
                S_OUT:
                    if (inst_ready_i) begin
                        state_d = S_REQ;
                        pc_d    = pc_q + XLEN'(4);
                    end
                default: state_d = imem_rsp_valid_i ? S_REQ : S_DRAIN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC & ~XLEN'(3);
            inst_q  <= '0;
            ipc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
        end
    end
endmodule
